sram_req_ctrl: RTL and testbench
================================

# sram_req_ctrl

Initiator-side controller for the 256x32 single-port SRAM wrapper (1rw port with active-low chip-select/write-enable and a byte write mask). It accepts read/write requests on a valid/ready handshake, drives the SRAM port cycle-accurately, and returns read data through a credit-protected response FIFO. After reset it optionally zero-fills the whole array before accepting traffic. It sits between the core's load/store or ICCM/DCCM request logic and the RAM wrapper.

## Interface
Parameters:
- ADDR_WIDTH, 8, word address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-mask width (DATA_WIDTH/8)
- MEMD, 256, words in the array; zero-fill covers 0..MEMD-1
- RSP_DEPTH, 3, response FIFO entries; minimum 3 for one read per cycle

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  NUM_WMASKS  byte enables (writes only)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  DATA_WIDTH  read data
- init_done  out  1  array ready; high until next reset
- csb  out  1  SRAM chip select, active low
- web  out  1  SRAM write enable, active low
- wmask  out  NUM_WMASKS  SRAM byte mask
- addr  out  ADDR_WIDTH  SRAM address
- din  out  DATA_WIDTH  SRAM write data
- dout  in  DATA_WIDTH  SRAM read data, valid the cycle after the read access cycle

## Operation
- States: INIT, RUN. Reset enters INIT.
- INIT: address counter 0..MEMD-1; each cycle csb=0, web=0, wmask=all ones, din=0, addr=counter. After the write of MEMD-1, go to RUN; init_done rises the next cycle. req_ready=0 throughout.
- RUN: req_ready = (fifo_count + inflight) < RSP_DEPTH, independent of req_write. On accept, same cycle: csb=0, web=~req_write, addr=req_addr, din=req_wdata, wmask=req_wmask (reads drive wmask=0). No accept: csb=1, web=1, other SRAM outputs hold their last value.
- Writes produce no response.
- Reads: inflight flag set for the following cycle; in that cycle dout is pushed into the FIFO. Push and pop in the same cycle are allowed; count unchanged.
- rsp_valid = FIFO non-empty; rsp_rdata = FIFO head; pop on rsp_valid & rsp_ready. Responses are returned in request order.
- Credit rule guarantees no FIFO overflow. A push into a full FIFO is a design error and must be flagged by a bench assertion.
- Read-after-write to the same address on consecutive accepts returns the new data; the SRAM orders the accesses, so no forwarding is needed.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, csb=1, web=1, wmask=0, addr=0, din=0, FIFO empty, inflight=0, counter=0.
- Read accepted in cycle T → SRAM access in T, dout sampled at end of T+1, rsp_valid high in T+2. Latency 2.
- Read throughput is one per cycle with rsp_ready held high and RSP_DEPTH≥3.
- Zero-fill takes MEMD cycles. With the default, the first accept is possible in cycle 257 after reset deassertion; init_done is high from that cycle.
- Reset asserted mid-operation: within the same clock, SRAM outputs return to idle (csb=1, web=1). FIFO contents and any in-flight read are dropped, and the block re-enters INIT (or RUN per Configuration).
- rsp_rdata is stable while rsp_valid=1 and rsp_ready=0.

## Configuration
- SRAM_ZERO_INIT_EN defined: INIT zero-fill as above.
- SRAM_ZERO_INIT_EN undefined: INIT lasts one cycle with no SRAM access. The block enters RUN and init_done=1 in the first cycle after reset deassertion, and array contents are undefined.

## Test plan
- Reset release with zero-fill enabled → exactly 256 write cycles, addr 0..255, din=0, wmask=4'hF; init_done rises the cycle after addr=255; a read of 0x80 returns 0x00000000.
- Write 0xDEADBEEF to 0x10 with mask 4'b0101, then read 0x10 → rsp_rdata 0x00AD00EF two cycles after the read accept.
- Back-to-back reads of 0x00..0x0F with rsp_ready=1 → 16 consecutive accepts, 16 in-order responses, no ready gaps.
- Hold rsp_ready=0 and issue reads → exactly 3 accepts, then req_ready=0; one pop re-opens exactly one credit; rsp_rdata stable while stalled.
- Assert rst with 2 responses buffered and 1 read in flight → next cycle rsp_valid=0, csb=1, init_done=0, and INIT restarts at addr 0.
- Build without SRAM_ZERO_INIT_EN → req_ready=1 and init_done=1 in the first cycle after reset; no SRAM writes occur.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready request controller for a 1rw SRAM with credit-protected read FIFO.
// Optional post-reset zero-fill of the array is enabled by defining SRAM_ZERO_INIT_EN.
module sram_req_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int MEMD       = 256,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb,
    output logic                  web,
    output logic [NUM_WMASKS-1:0] wmask,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {INIT, RUN} state_e;

`ifdef SRAM_ZERO_INIT_EN
    localparam state_e RST_STATE = INIT;
    localparam logic   RST_DONE  = 1'b0;
`else
    // Without zero-fill the reset cycle itself is the whole INIT phase.
    localparam state_e RST_STATE = RUN;
    localparam logic   RST_DONE  = 1'b1;
`endif

    state_e                state_q;
    logic                  init_done_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [NUM_WMASKS-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [CW-1:0]         fcnt_q;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  fill;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [CW:0]           used;

`ifdef SRAM_ZERO_INIT_EN
    logic [ADDR_WIDTH-1:0] cnt_q;
    assign fill      = ~rst && (state_q == INIT);
    assign fill_addr = cnt_q;
`else
    assign fill      = 1'b0;
    assign fill_addr = '0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count both buffered and in-flight reads so a push never overflows.
    assign used      = {1'b0, fcnt_q} + (CW+1)'(inflight_q);
    assign req_ready = ~rst && (state_q == RUN) && (used < (CW+1)'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = inflight_q;
    assign rsp_valid = ~rst && (fcnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_q[rptr_q] : '0;
    assign init_done = ~rst & init_done_q;

    always_comb begin
        csb   = 1'b1;
        web   = 1'b1;
        addr  = addr_q;
        din   = din_q;
        wmask = wmask_q;
        if (rst) begin
            addr  = '0;
            din   = '0;
            wmask = '0;
        end else if (fill) begin
            csb   = 1'b0;
            web   = 1'b0;
            addr  = fill_addr;
            din   = '0;
            wmask = '1;
        end else if (accept) begin
            csb   = 1'b0;
            web   = ~req_write;
            addr  = req_addr;
            din   = req_wdata;
            wmask = req_write ? req_wmask : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            init_done_q <= RST_DONE;
            inflight_q  <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            wmask_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fcnt_q      <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
`ifdef SRAM_ZERO_INIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            addr_q     <= addr;
            din_q      <= din;
            wmask_q    <= wmask;
            inflight_q <= accept & ~req_write;
`ifdef SRAM_ZERO_INIT_EN
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(MEMD - 1)) begin
                    state_q     <= RUN;
                    init_done_q <= 1'b1;
                end
            end
`endif
            if (push) begin
                fifo_q[wptr_q] <= dout;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed vectors against sram_req_ctrl with a behavioural 1rw SRAM.
// Honours SRAM_ZERO_INIT_EN the same way as the design.
module tb_sram_req_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        init_done, csb, web;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din, dout;

    int tests = 0;
    int fails = 0;

`ifdef SRAM_ZERO_INIT_EN
    localparam bit ZI = 1'b1;
`else
    localparam bit ZI = 1'b0;
`endif

    sram_req_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .csb(csb), .web(web), .wmask(wmask),
        .addr(addr), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: array starts all ones so zero-fill is observable.
    logic [31:0] mem [256];
    logic        mem_init = 1'b0;
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hFFFF_FFFF;
            mem_init <= 1'b1;
        end else if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
                wr_cnt <= wr_cnt + 1;
            end else begin
                dout <= mem[addr];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dut.inflight_q && dut.fcnt_q == 3) begin
            fails++;
            $display("FAIL fifo_overflow: push into full response FIFO at %0t", $time);
        end
    end

    typedef struct {
        logic        v, w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  m;
        logic        rr;
        logic        e_rdy, e_rv;
        logic [31:0] e_rd;
        logic        e_csb, e_web;
        logic [3:0]  e_m;
        logic [7:0]  e_a;
    } vec_t;

    function automatic vec_t mk(logic v, logic w, logic [7:0] a, logic [31:0] wd,
                                logic [3:0] m, logic rr, logic rdy, logic rv,
                                logic [31:0] rd, logic cs, logic we,
                                logic [3:0] em, logic [7:0] ea);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.wd = wd; t.m = m; t.rr = rr;
        t.e_rdy = rdy; t.e_rv = rv; t.e_rd = rd; t.e_csb = cs; t.e_web = we;
        t.e_m = em; t.e_a = ea;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        int w0;
        for (int k = 0; k < 2; k++) begin
            tick();
            rst = 1'b1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("rst%0d_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("rst%0d_rv", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("rst%0d_rdata", k), rsp_rdata, 32'd0);
            chk($sformatf("rst%0d_done", k), 32'(init_done), 32'd0);
            chk($sformatf("rst%0d_csb_web", k), {30'd0, csb, web}, 32'd3);
            chk($sformatf("rst%0d_sram", k), {wmask, addr, din[19:0]}, 32'd0);
            chk($sformatf("rst%0d_din", k), din, 32'd0);
        end
        tick();
        idle();
        rst = 1'b0;
        w0 = wr_cnt;
`ifdef SRAM_ZERO_INIT_EN
        // A pending request during zero-fill must not be accepted.
        req_valid = 1'b1;
        req_addr  = 8'h44;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) tick();
            @(negedge clk);
            chk($sformatf("init_cyc%0d", i),
                {15'd0, csb, web, wmask, req_ready, init_done, din == 32'd0, addr},
                {15'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'(i)});
        end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("init_done_rise", 32'(init_done), 32'd1);
        chk("init_ready", 32'(req_ready), 32'd1);
        chk("init_csb_idle", 32'(csb), 32'd1);
        chk("init_rv", 32'(rsp_valid), 32'd0);
        chk("init_wr_count", 32'(wr_cnt - w0), 32'd256);
`else
        @(negedge clk);
        chk("noinit_done", 32'(init_done), 32'd1);
        chk("noinit_ready", 32'(req_ready), 32'd1);
        chk("noinit_csb", 32'(csb), 32'd1);
        chk("noinit_rv", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("noinit_wr_count", 32'(wr_cnt - w0), 32'd0);
`endif
    endtask

    task automatic do_read(input string nm, input logic [7:0] a, input logic [31:0] exp);
        bit got;
        tick();
        idle();
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(req_ready), 32'd1);
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                chk({nm, "_lat"}, 32'(k), 32'd2);
                chk({nm, "_data"}, rsp_rdata, exp);
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no response within 6 cycles", nm);
        end
    endtask

    vec_t tbl[11];

    initial begin
        int acc, got, first;
        tbl[0]  = mk(1,1,8'h10,32'h0000_0000,4'hF,1, 1,0,32'h0,0,0,4'hF,8'h10);
        tbl[1]  = mk(1,1,8'h10,32'hDEAD_BEEF,4'h5,1, 1,0,32'h0,0,0,4'h5,8'h10);
        tbl[2]  = mk(1,0,8'h10,32'h0000_0000,4'hF,1, 1,0,32'h0,0,1,4'h0,8'h10);
        tbl[3]  = mk(0,0,8'h33,32'h0000_0000,4'hF,1, 1,0,32'h0,1,1,4'h0,8'h10);
        tbl[4]  = mk(0,0,8'h00,32'h0000_0000,4'h0,1, 1,1,32'h00AD_00EF,1,1,4'h0,8'h10);
        tbl[5]  = mk(1,1,8'h20,32'h1234_5678,4'hF,1, 1,0,32'h0,0,0,4'hF,8'h20);
        tbl[6]  = mk(1,0,8'h20,32'h0000_0000,4'h0,1, 1,0,32'h0,0,1,4'h0,8'h20);
        tbl[7]  = mk(1,0,8'h10,32'h0000_0000,4'h0,1, 1,0,32'h0,0,1,4'h0,8'h10);
        tbl[8]  = mk(0,0,8'h00,32'h0000_0000,4'h0,1, 1,1,32'h1234_5678,1,1,4'h0,8'h10);
        tbl[9]  = mk(0,0,8'h00,32'h0000_0000,4'h0,1, 1,1,32'h00AD_00EF,1,1,4'h0,8'h10);
        tbl[10] = mk(0,0,8'h00,32'h0000_0000,4'h0,1, 1,0,32'h0,1,1,4'h0,8'h10);

        rst = 1'b1;
        idle();
        do_reset();
        if (ZI) do_read("zf_read80", 8'h80, 32'h0);

        for (int r = 0; r < 11; r++) begin
            tick();
            req_valid = tbl[r].v; req_write = tbl[r].w; req_addr = tbl[r].a;
            req_wdata = tbl[r].wd; req_wmask = tbl[r].m; rsp_ready = tbl[r].rr;
            @(negedge clk);
            chk($sformatf("t%0d_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("t%0d_rv", r), 32'(rsp_valid), 32'(tbl[r].e_rv));
            if (tbl[r].e_rv) chk($sformatf("t%0d_rdata", r), rsp_rdata, tbl[r].e_rd);
            chk($sformatf("t%0d_csb_web", r), {30'd0, csb, web}, {30'd0, tbl[r].e_csb, tbl[r].e_web});
            chk($sformatf("t%0d_wmask", r), 32'(wmask), 32'(tbl[r].e_m));
            chk($sformatf("t%0d_addr", r), 32'(addr), 32'(tbl[r].e_a));
        end

        // Back-to-back: 16 writes, then 16 reads with no ready gaps.
        for (int i = 0; i < 16; i++) begin
            tick();
            idle();
            req_valid = 1'b1; req_write = 1'b1; req_addr = 8'(i);
            req_wdata = 32'hA000_0000 | 32'(i); req_wmask = 4'hF;
            @(negedge clk);
            chk($sformatf("b2b_wr%0d_rdy", i), 32'(req_ready), 32'd1);
        end
        got = 0;
        first = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            idle();
            rsp_ready = 1'b1;
            if (c < 16) begin
                req_valid = 1'b1; req_addr = 8'(c);
            end
            @(negedge clk);
            if (c < 16) chk($sformatf("b2b_rd%0d_rdy", c), 32'(req_ready), 32'd1);
            if (rsp_valid) begin
                if (first < 0) first = c;
                chk($sformatf("b2b_rsp%0d", got), rsp_rdata, 32'hA000_0000 | 32'(got));
                got++;
            end
        end
        chk("b2b_count", 32'(got), 32'd16);
        chk("b2b_latency", 32'(first), 32'd2);

        // Stall with rsp_ready low: exactly three credits.
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            idle();
            req_valid = 1'b1; req_addr = 8'(acc);
            @(negedge clk);
            if (c == 5) chk("stall_ready_low", 32'(req_ready), 32'd0);
            if (rsp_valid) chk($sformatf("stall_hold%0d", c), rsp_rdata, 32'hA000_0000);
            if (req_ready) acc++;
        end
        chk("stall_accepts", 32'(acc), 32'd3);
        tick();
        idle();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("pop_rv", 32'(rsp_valid), 32'd1);
        chk("pop_rdata", rsp_rdata, 32'hA000_0000);
        chk("pop_ready_closed", 32'(req_ready), 32'd0);
        tick();
        idle();
        req_valid = 1'b1; req_addr = 8'h03;
        @(negedge clk);
        chk("credit_open", 32'(req_ready), 32'd1);
        chk("credit_head", rsp_rdata, 32'hA000_0001);
        tick();
        req_addr = 8'h04;
        @(negedge clk);
        chk("credit_closed", 32'(req_ready), 32'd0);
        got = 0;
        for (int k = 0; k < 8 && got < 3; k++) begin
            tick();
            idle();
            rsp_ready = 1'b1;
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("drain%0d", got), rsp_rdata, 32'hA000_0001 + 32'(got));
                got++;
            end
        end
        chk("drain_count", 32'(got), 32'd3);

        // Two responses buffered, one read in flight, then reset.
        for (int c = 0; c < 3; c++) begin
            tick();
            idle();
            req_valid = 1'b1; req_addr = 8'(5 + c);
            @(negedge clk);
            chk($sformatf("pre_rst_rd%0d", c), 32'(req_ready), 32'd1);
        end
        do_reset();
        do_read("post_rst_read10", 8'h10, ZI ? 32'h0 : 32'h00AD_00EF);
        if (ZI) do_read("post_rst_read80", 8'h80, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
